tick_speed_decoder: RTL and testbench
=====================================

Name: tick_speed_decoder

Overview:
- Receiver side of the prescaler tick interface: watches a single-cycle tick stream and measures the tick period in clk_i cycles.
- Recovers the 4-bit speed code that produced the stream, and flags lock (stable period) and loss of ticks (timeout).
- Sits beside the spinner logic as a self-check/telemetry block, e.g. feeding speed back to a display or a debug port.

Parameters:
- CNT_W, 26, counter/period width; covers 12_500_000 cycles (4 Hz at 50 MHz).
- TOL, 4, allowed absolute deviation in cycles for lock and code match.
- TIMEOUT, 33_554_431, cycles without a tick before declaring loss; must be less than or equal to 2^CNT_W-1.

Ports:
- clk_i  in  1  system clock, 50 MHz.
- rst_i  in  1  synchronous, active-high reset.
- tick_i  in  1  tick pulse, one clk_i cycle wide, synchronous to clk_i.
- period_o  out  CNT_W  last measured tick-to-tick distance in cycles.
- valid_o  out  1  one-cycle pulse when period_o updates.
- locked_o  out  1  two consecutive periods agree within TOL.
- speed_o  out  4  recovered speed code; valid while match_o=1.
- match_o  out  1  period_o matches a table entry within TOL.
- timeout_o  out  1  level; set on tick loss, cleared by the next tick.

Behaviour:
- Reset, when rst_i=1 at a clk_i edge: state=IDLE, cnt=0, period_o=0, valid_o=0, locked_o=0, speed_o=0, match_o=0, timeout_o=0.
- Reset takes priority over everything; asserting it mid-measurement discards the partial count.
- State IDLE:
  - First tick_i moves to MEASURE and loads cnt=1.
  - No valid_o pulse on this first tick (arm only).
  - timeout_o clears on this tick.
- State MEASURE/LOCKED, counting:
  - Each cycle without a tick: cnt increments.
  - On tick_i: period_o<=cnt, valid_o=1 the next cycle (registered, latency 1), cnt reloads to 1.
  - Result: ticks at cycles t0, t1 give period_o = t1-t0.
- Lock:
  - On each capture, compare the new period with the previous one (prev register, width CNT_W).
  - |new-prev| <= TOL: go to or stay in LOCKED, locked_o=1.
  - Otherwise: go to MEASURE, locked_o=0.
  - The first capture after IDLE has no prev, so it never locks.
- Classification (period_classifier, combinational on the captured period, registered with period_o):
  - Scan codes 0..15; a match is |period - PERIOD_OF(code)| <= TOL.
  - Lowest matching code wins; match_o=1, speed_o=code.
  - No match: match_o=0, speed_o holds its previous value.
- Arithmetic: absolute difference computed at CNT_W+1 bits; no wrap. cnt saturates at TIMEOUT and never wraps.
- Timeout:
  - cnt reaching TIMEOUT with no tick: state=IDLE, timeout_o=1, locked_o=0, match_o=0.
  - period_o and speed_o hold their last values.
- Simultaneous events:
  - tick_i in the same cycle cnt reaches TIMEOUT: the tick wins and is captured as a normal period (period_o=TIMEOUT).
  - tick_i during rst_i: ignored.
- Back-to-back ticks on consecutive cycles are legal: period_o=1.

Decomposition:
- Shared header tick_speed_defs.vh, also used by the prescaler, holds:
  - The speed code width (4).
  - Function PERIOD_OF(code), the tick period in clk_i cycles per code; the 4'b1111 entry is 12_500_000 and the default entry is 6_250_000.
  - Under define TICK_SIM, PERIOD_OF(code) = 16*(code+1) for short simulations.
- One sub-module: period_classifier, a combinational period-to-{speed, match} lookup.
- State encoding (IDLE, MEASURE, LOCKED) stays local.

Test Plan:
- All cases run with TICK_SIM, TOL=2, TIMEOUT=1000.
- Reset held with ticks every 48 cycles -> all outputs stay 0; after release, first tick gives no valid_o; second tick -> period_o=48, valid_o single pulse one cycle later, speed_o=2, match_o=1, locked_o=0; third tick -> locked_o=1.
- Ticks at 48 then 47 then 50 -> locked stays 1 at 47 (diff 1); 50 (diff 3) -> locked_o=0, still match_o=1, speed_o=2.
- Period 56 -> match_o=0, speed_o holds 2; next period 256 -> speed_o=15, match_o=1.
- Stop ticks -> exactly 1000 cycles after the last tick timeout_o=1, locked_o=0, match_o=0, period_o holds; next tick clears timeout_o with no valid_o; the following tick resumes measurement.
- Tick coincident with cnt=1000 -> captured, period_o=1000, timeout_o stays 0.
- Ticks on cycles 10 and 11 -> period_o=1; rst_i pulsed between two ticks 48 apart -> no valid_o for the interrupted interval.

Source files
------------

// File: rtl/tick_speed_decoder_pkg.sv
// rtl/tick_speed_decoder_pkg.sv - shared speed code width and tick period table
package tick_speed_decoder_pkg;

  localparam int SPEED_W  = 4;
  localparam int PERIOD_W = 26;

  // Tick period in clk_i cycles for each speed code; sim selects the short table.
  function automatic logic [PERIOD_W-1:0] period_of(input logic [SPEED_W-1:0] code,
                                                    input bit sim);
    logic [PERIOD_W-1:0] p;
    if (sim) begin
      p = (PERIOD_W'(code) + PERIOD_W'(1)) << 4;
    end else begin
      case (code)
        4'd0:    p = PERIOD_W'(50_000);
        4'd1:    p = PERIOD_W'(100_000);
        4'd2:    p = PERIOD_W'(200_000);
        4'd3:    p = PERIOD_W'(250_000);
        4'd4:    p = PERIOD_W'(500_000);
        4'd5:    p = PERIOD_W'(1_000_000);
        4'd6:    p = PERIOD_W'(1_250_000);
        4'd7:    p = PERIOD_W'(2_500_000);
        4'd8:    p = PERIOD_W'(3_125_000);
        4'd9:    p = PERIOD_W'(5_000_000);
        4'd15:   p = PERIOD_W'(12_500_000);
        default: p = PERIOD_W'(6_250_000);
      endcase
    end
    return p;
  endfunction

  // Sim builds select the short period table unless overridden at instantiation.
`ifdef TICK_SIM
  localparam bit SIM_TABLE_DEFAULT = 1'b1;
`else
  localparam bit SIM_TABLE_DEFAULT = 1'b0;
`endif

endpackage

// File: rtl/tick_speed_decoder_classifier.sv
// rtl/tick_speed_decoder_classifier.sv - combinational period to speed code lookup
module period_classifier
  import tick_speed_decoder_pkg::*;
#(
  parameter int CNT_W     = 26,
  parameter int TOL       = 4,
  parameter bit SIM_TABLE = SIM_TABLE_DEFAULT
) (
  input  logic [CNT_W-1:0]   period_i,
  output logic [SPEED_W-1:0] speed_o,
  output logic               match_o
);

  // Compare at one bit wider than either operand so the subtraction never wraps.
  localparam int DW = ((CNT_W > PERIOD_W) ? CNT_W : PERIOD_W) + 1;

  logic [DW-1:0] p_ext;
  logic [DW-1:0] r_ext;
  logic [DW-1:0] diff;

  assign p_ext = DW'(period_i);

  // Scan from the top code down so the lowest matching code is the one left standing.
  always_comb begin
    speed_o = '0;
    match_o = 1'b0;
    r_ext   = '0;
    diff    = '0;
    for (int i = 15; i >= 0; i--) begin
      r_ext = DW'(period_of(SPEED_W'(i), SIM_TABLE));
      diff  = (p_ext >= r_ext) ? (p_ext - r_ext) : (r_ext - p_ext);
      if (diff <= DW'(TOL)) begin
        speed_o = SPEED_W'(i);
        match_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_speed_decoder.sv
// rtl/tick_speed_decoder.sv - tick period measurement, lock, speed recovery and timeout
module tick_speed_decoder
  import tick_speed_decoder_pkg::*;
#(
  parameter int CNT_W     = 26,
  parameter int TOL       = 4,
  parameter int TIMEOUT   = 33_554_431,
  parameter bit SIM_TABLE = SIM_TABLE_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick_i,
  output logic [CNT_W-1:0]   period_o,
  output logic               valid_o,
  output logic               locked_o,
  output logic [SPEED_W-1:0] speed_o,
  output logic               match_o,
  output logic               timeout_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [CNT_W-1:0]   period_q,  period_d;
  logic               valid_q,   valid_d;
  logic               locked_q,  locked_d;
  logic [SPEED_W-1:0] speed_q,   speed_d;
  logic               match_q,   match_d;
  logic               timeout_q, timeout_d;
  logic               prev_ok_q, prev_ok_d;

  logic [SPEED_W-1:0] cls_speed;
  logic               cls_match;
  logic [CNT_W:0]     lock_diff;

  // Classify the count being captured; the result is registered alongside period_q.
  period_classifier #(
    .CNT_W    (CNT_W),
    .TOL      (TOL),
    .SIM_TABLE(SIM_TABLE)
  ) u_classifier (
    .period_i(cnt_q),
    .speed_o (cls_speed),
    .match_o (cls_match)
  );

  // Distance between the incoming period and the previously captured one.
  always_comb begin
    lock_diff = ({1'b0, cnt_q} >= {1'b0, period_q}) ? ({1'b0, cnt_q} - {1'b0, period_q})
                                                    : ({1'b0, period_q} - {1'b0, cnt_q});
  end

  // Next-state logic: arm in IDLE, count and capture otherwise, fall back on timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    speed_d   = speed_q;
    match_d   = match_q;
    timeout_d = timeout_q;
    prev_ok_d = prev_ok_q;
    case (state_q)
      S_IDLE: begin
        if (tick_i) begin
          state_d   = S_MEASURE;
          cnt_d     = CNT_W'(1);
          timeout_d = 1'b0;
          prev_ok_d = 1'b0;
        end
      end
      S_MEASURE, S_LOCKED: begin
        if (tick_i) begin
          // A tick on the same cycle the count hits TIMEOUT still counts as a period.
          period_d  = cnt_q;
          valid_d   = 1'b1;
          cnt_d     = CNT_W'(1);
          prev_ok_d = 1'b1;
          if (prev_ok_q && (lock_diff <= (CNT_W+1)'(TOL))) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
          end else begin
            state_d  = S_MEASURE;
            locked_d = 1'b0;
          end
          match_d = cls_match;
          if (cls_match) begin
            speed_d = cls_speed;
          end
        end else if (cnt_q >= TIMEOUT_C) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          match_d   = 1'b0;
          prev_ok_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over any tick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      speed_q   <= '0;
      match_q   <= 1'b0;
      timeout_q <= 1'b0;
      prev_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      speed_q   <= speed_d;
      match_q   <= match_d;
      timeout_q <= timeout_d;
      prev_ok_q <= prev_ok_d;
    end
  end

  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign locked_o  = locked_q;
  assign speed_o   = speed_q;
  assign match_o   = match_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_tick_speed_decoder.sv
// tb/tb_tick_speed_decoder.sv - directed self-checking bench for tick_speed_decoder
module tb_tick_speed_decoder;

  localparam int CNT_W = 26;

  logic             clk_i;
  logic             rst_i;
  logic             tick_i;
  logic [CNT_W-1:0] period_o;
  logic             valid_o;
  logic             locked_o;
  logic [3:0]       speed_o;
  logic             match_o;
  logic             timeout_o;

  int passed;
  int total;

  tick_speed_decoder #(
    .CNT_W    (CNT_W),
    .TOL      (2),
    .TIMEOUT  (1000),
    .SIM_TABLE(1'b1)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tick_i   (tick_i),
    .period_o (period_o),
    .valid_o  (valid_o),
    .locked_o (locked_o),
    .speed_o  (speed_o),
    .match_o  (match_o),
    .timeout_o(timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock cycle with tick_i held at t; outputs are settled 1 time unit after the edge.
  task automatic step(input logic t);
    tick_i = t;
    @(posedge clk_i);
    #1;
    tick_i = 1'b0;
  endtask

  // Tick n cycles after the previous tick.
  task automatic gap(input int n);
    for (int i = 0; i < n - 1; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"},  32'(period_o),  32'd0);
    check({tag, "_valid"},   32'(valid_o),   32'd0);
    check({tag, "_locked"},  32'(locked_o),  32'd0);
    check({tag, "_speed"},   32'(speed_o),   32'd0);
    check({tag, "_match"},   32'(match_o),   32'd0);
    check({tag, "_timeout"}, 32'(timeout_o), 32'd0);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_i  = 1'b1;
    tick_i = 1'b0;

    // Ticks every 48 cycles while reset is held: nothing moves.
    step(1'b1);
    gap(48);
    check_all_zero("rst_hold_a");
    gap(48);
    check_all_zero("rst_hold_b");

    rst_i = 1'b0;
    step(1'b0);
    step(1'b0);

    // First tick arms only.
    step(1'b1);
    check("arm_valid", 32'(valid_o), 32'd0);

    // Second tick: period 48, code 2, not yet locked.
    gap(48);
    check("p48_valid",  32'(valid_o),  32'd1);
    check("p48_period", 32'(period_o), 32'd48);
    check("p48_speed",  32'(speed_o),  32'd2);
    check("p48_match",  32'(match_o),  32'd1);
    check("p48_locked", 32'(locked_o), 32'd0);
    step(1'b0);
    check("p48_pulse_end", 32'(valid_o), 32'd0);

    // Third tick at 48 again: locked.
    gap(47);
    check("p48b_period", 32'(period_o), 32'd48);
    check("p48b_locked", 32'(locked_o), 32'd1);

    // 47: diff 1, stays locked.
    gap(47);
    check("p47_period", 32'(period_o), 32'd47);
    check("p47_locked", 32'(locked_o), 32'd1);
    check("p47_speed",  32'(speed_o),  32'd2);

    // 50: diff 3 drops lock, still within code 2 tolerance.
    gap(50);
    check("p50_period", 32'(period_o), 32'd50);
    check("p50_locked", 32'(locked_o), 32'd0);
    check("p50_match",  32'(match_o),  32'd1);
    check("p50_speed",  32'(speed_o),  32'd2);

    // 56: between codes, no match, speed holds.
    gap(56);
    check("p56_period", 32'(period_o), 32'd56);
    check("p56_match",  32'(match_o),  32'd0);
    check("p56_speed",  32'(speed_o),  32'd2);

    // 256: top code.
    gap(256);
    check("p256_period", 32'(period_o), 32'd256);
    check("p256_speed",  32'(speed_o),  32'd15);
    check("p256_match",  32'(match_o),  32'd1);

    // Stop ticking: timeout exactly 1000 cycles after the last tick.
    for (int i = 0; i < 999; i++) step(1'b0);
    check("to_before", 32'(timeout_o), 32'd0);
    step(1'b0);
    check("to_set",    32'(timeout_o), 32'd1);
    check("to_locked", 32'(locked_o),  32'd0);
    check("to_match",  32'(match_o),   32'd0);
    check("to_period", 32'(period_o),  32'd256);
    check("to_speed",  32'(speed_o),   32'd15);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("to_clear",       32'(timeout_o), 32'd0);
    check("to_clear_valid", 32'(valid_o),   32'd0);
    gap(48);
    check("resume_valid",  32'(valid_o),  32'd1);
    check("resume_period", 32'(period_o), 32'd48);
    check("resume_locked", 32'(locked_o), 32'd0);
    check("resume_speed",  32'(speed_o),  32'd2);

    // Tick coincident with cnt reaching TIMEOUT is captured.
    gap(1000);
    check("edge_valid",   32'(valid_o),   32'd1);
    check("edge_period",  32'(period_o),  32'd1000);
    check("edge_timeout", 32'(timeout_o), 32'd0);
    check("edge_match",   32'(match_o),   32'd0);
    check("edge_speed",   32'(speed_o),   32'd2);

    // Back-to-back ticks.
    gap(1);
    check("b2b_valid",  32'(valid_o),  32'd1);
    check("b2b_period", 32'(period_o), 32'd1);

    // Reset between two ticks 48 apart discards the interval.
    gap(5);
    for (int i = 0; i < 20; i++) step(1'b0);
    rst_i = 1'b1;
    step(1'b0);
    rst_i = 1'b0;
    check_all_zero("mid_rst");
    for (int i = 0; i < 26; i++) step(1'b0);
    step(1'b1);
    check("mid_rst_valid",  32'(valid_o),  32'd0);
    check("mid_rst_period", 32'(period_o), 32'd0);
    gap(48);
    check("after_rst_valid",  32'(valid_o),  32'd1);
    check("after_rst_period", 32'(period_o), 32'd48);
    check("after_rst_locked", 32'(locked_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
